prog_counter: RTL and testbench
===============================

# prog_counter

Program-counter and fetch-sequencing stage for the sample processor. Each cycle it advances the 10-bit instruction address either sequentially or by a signed relative offset supplied by the branch-target lookup table. It also runs the start/halt handshake with the test harness and keeps executed-instruction and taken-branch counts. Its PC output drives instruction-memory addressing, and its Target input comes straight from the lookup-table stage.

## Interface
- PC_W, 10: PC and branch-offset width.
- START_ADDR, 0: PC value loaded on reset and on every accepted Start.
- CNT_W, 16: width of InstCount and BranchCount.

- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin or restart program; sampled in IDLE and DONE only.
- Stall  in  1  current instruction not executing this cycle; freeze.
- Halt  in  1  instruction at PC is the halt instruction.
- BranchEn  in  1  instruction at PC is a relative branch.
- BrTaken  in  1  branch condition true; meaningful only with BranchEn.
- Target  in  PC_W  two's-complement relative offset from the lookup table.
- PC  out  PC_W  current instruction address, registered.
- Running  out  1  high while in RUN, registered.
- Done  out  1  high while in DONE, registered.
- InstCount  out  CNT_W  instructions retired since last Start, saturating.
- BranchCount  out  CNT_W  taken branches since last Start, saturating.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered flops.
- Reset asserted, at any time and from any state:
  - Forces IDLE immediately.
  - PC = START_ADDR; Running = 0; Done = 0; both counters = 0.
- IDLE:
  - Start=1: next state RUN, PC = START_ADDR, counters cleared.
  - Otherwise hold.
- RUN: at most one action per cycle, evaluated in this priority order.
  1. Stall=1: PC, counters and state all hold. Halt and branch inputs are ignored.
  2. Halt=1: next state DONE. PC holds at the halt address. InstCount += 1.
  3. BranchEn=1 and BrTaken=1:
     - PC = (PC + Target) mod 2^PC_W. Target is signed, so 10'h3fb means −5.
     - InstCount += 1; BranchCount += 1.
  4. Otherwise, including BranchEn=1 with BrTaken=0: PC = (PC + 1) mod 2^PC_W; InstCount += 1.
- Start is ignored in RUN.
- DONE:
  - PC and counters hold. Done = 1.
  - Start=1: next state RUN, PC = START_ADDR, counters cleared, Done drops.
- Arithmetic:
  - PC addition is PC_W bits; the carry is discarded, so wrap-around in both directions is legal.
  - Counters stick at all-ones and never wrap.
- BrTaken without BranchEn has no effect.

## Timing
- Every input is sampled on the rising Clk edge. The effect is visible on the outputs in the following cycle (1-cycle latency).
- The Start pulse in IDLE or DONE at edge N:
  - Running = 1 and PC = START_ADDR after edge N.
  - The first instruction executes at edge N+1.
- Halt at edge N: Done = 1 and Running = 0 after edge N.
- Target, BranchEn, BrTaken and Halt are combinational functions of the current PC. They must be valid for the whole cycle in which PC is presented.
- Reset deassertion is synchronized externally. The block leaves IDLE no earlier than the first edge at which Reset is high and Start = 1.

## Test plan
- Reset values: pulse Reset low mid-cycle while in RUN with PC=37.
  - PC=0, Running=0, Done=0, counts=0 immediately, without waiting for an edge.
- Sequential run:
  - Stimulus: Start one cycle, then 5 plain cycles.
  - Response: PC steps 0,1,2,3,4,5. InstCount=5, BranchCount=0.
- Branches at PC=10:
  - Taken branch with Target=10'h3fb: PC becomes 5, BranchCount=1.
  - Taken branch at PC=5 with Target=10'h002: PC becomes 7.
  - Untaken branch at PC=7 with Target=10'h3ef: PC becomes 8.
- Wrap-around:
  - PC=0, taken branch with Target=10'h3ef (−17): PC becomes 1007.
  - PC=1023, plain step: PC becomes 0.
- Stall and halt:
  - Stall=1 with Halt=1 for 3 cycles at PC=4: PC, counts and state unchanged.
  - Stall=0 with Halt=1: Done=1, PC=4, InstCount incremented once. Further cycles hold.
  - Start in DONE: PC=0, counts=0, Running=1.
- Saturation (CNT_W=4):
  - Stimulus: 20 plain instructions, with 17 taken branches among them.
  - Response: InstCount=15 and BranchCount=15, both held. PC keeps advancing.

Source files
------------

// File: rtl/prog_counter.sv
// Program counter and fetch sequencer: steps the instruction address
// sequentially or by a signed relative branch offset, runs the
// IDLE/RUN/DONE start-halt handshake and keeps saturating counts of
// retired instructions and taken branches since the last Start.
module prog_counter #(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = {PC_W{1'b0}},
    parameter int              CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic             BrTaken,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstCount,
    output logic [CNT_W-1:0] BranchCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state, next-PC and next-count selection; RUN actions are prioritised
    // stall > halt > taken branch > sequential step.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_cnt_d = inst_cnt_q;
        br_cnt_d   = br_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d    = ST_RUN;
                    pc_d       = START_ADDR;
                    inst_cnt_d = {CNT_W{1'b0}};
                    br_cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (Stall) begin
                    state_d = ST_RUN;
                end else if (Halt) begin
                    // PC stays on the halt instruction's address.
                    state_d    = ST_DONE;
                    inst_cnt_d = sat_inc(inst_cnt_q);
                end else if (BranchEn && BrTaken) begin
                    // Same-width add: two's-complement offset, carry discarded.
                    pc_d       = pc_q + Target;
                    inst_cnt_d = sat_inc(inst_cnt_q);
                    br_cnt_d   = sat_inc(br_cnt_q);
                end else begin
                    pc_d       = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    inst_cnt_d = sat_inc(inst_cnt_q);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                pc_d       = START_ADDR;
                inst_cnt_d = {CNT_W{1'b0}};
                br_cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        // Status flags are derived from the next state so they are flop outputs.
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // State, PC, status flags and counters; reset forces IDLE immediately.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= START_ADDR;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            inst_cnt_q <= {CNT_W{1'b0}};
            br_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            running_q  <= running_d;
            done_q     <= done_d;
            inst_cnt_q <= inst_cnt_d;
            br_cnt_q   <= br_cnt_d;
        end
    end

    assign PC          = pc_q;
    assign Running     = running_q;
    assign Done        = done_q;
    assign InstCount   = inst_cnt_q;
    assign BranchCount = br_cnt_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: a vector table for the directed
// scenarios, hand-written reset and saturation sequences, and randomized
// stimulus checked against an arithmetic reference model. A second
// instance with 4-bit counters shares all inputs to exercise saturation.
module tb_prog_counter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Stall = 1'b0;
    logic       Halt = 1'b0;
    logic       BranchEn = 1'b0;
    logic       BrTaken = 1'b0;
    logic [9:0] Target = 10'd0;

    logic [9:0]  pc_m, pc_s;
    logic        run_m, run_s, done_m, done_s;
    logic [15:0] ic_m, bc_m;
    logic [3:0]  ic_s, bc_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: counts are unbounded, saturation applied on compare.
    int   m_pc = 0;
    logic m_run = 1'b0;
    logic m_done = 1'b0;
    int   m_ic = 0;
    int   m_bc = 0;

    always #5 Clk = ~Clk;

    prog_counter #(.PC_W(10), .START_ADDR(10'd0), .CNT_W(16)) u_main (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
        .BranchEn(BranchEn), .BrTaken(BrTaken), .Target(Target),
        .PC(pc_m), .Running(run_m), .Done(done_m),
        .InstCount(ic_m), .BranchCount(bc_m)
    );

    prog_counter #(.PC_W(10), .START_ADDR(10'd0), .CNT_W(4)) u_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
        .BranchEn(BranchEn), .BrTaken(BrTaken), .Target(Target),
        .PC(pc_s), .Running(run_s), .Done(done_s),
        .InstCount(ic_s), .BranchCount(bc_s)
    );

    typedef struct {
        logic       start, stall, halt, ben, btk;
        logic [9:0] target;
        int         pc;
        logic       run, done;
        int         ic, bc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic st, input logic h,
                                input logic be, input logic bt, input logic [9:0] tg,
                                input int pc, input logic r, input logic d,
                                input int ic, input int bc);
        vec_t v;
        v.start = s; v.stall = st; v.halt = h; v.ben = be; v.btk = bt;
        v.target = tg; v.pc = pc; v.run = r; v.done = d; v.ic = ic; v.bc = bc;
        return v;
    endfunction

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int pc, input logic r,
                             input logic d, input int ic, input int bc);
        chk({tag, ".pc"},     {22'd0, pc_m},  pc);
        chk({tag, ".run"},    {31'd0, run_m}, {31'd0, r});
        chk({tag, ".done"},   {31'd0, done_m}, {31'd0, d});
        chk({tag, ".ic"},     {16'd0, ic_m},  sat(ic, 16));
        chk({tag, ".bc"},     {16'd0, bc_m},  sat(bc, 16));
        chk({tag, ".s_pc"},   {22'd0, pc_s},  pc);
        chk({tag, ".s_ic"},   {28'd0, ic_s},  sat(ic, 4));
        chk({tag, ".s_bc"},   {28'd0, bc_s},  sat(bc, 4));
    endtask

    task automatic set_in(input logic s, input logic st, input logic h,
                          input logic be, input logic bt, input logic [9:0] tg);
        Start = s; Stall = st; Halt = h; BranchEn = be; BrTaken = bt; Target = tg;
    endtask

    function automatic void model_reset();
        m_pc = 0; m_run = 1'b0; m_done = 1'b0; m_ic = 0; m_bc = 0;
    endfunction

    // Behavioural rules: one edge of the program-counter stage.
    function automatic void model_edge(input logic s, input logic st, input logic h,
                                       input logic be, input logic bt, input logic [9:0] tg);
        int off;
        if (!m_run) begin
            if (s) begin
                m_run = 1'b1; m_done = 1'b0; m_pc = 0; m_ic = 0; m_bc = 0;
            end
        end else if (st) begin
            m_run = 1'b1;
        end else if (h) begin
            m_run = 1'b0; m_done = 1'b1; m_ic = m_ic + 1;
        end else if (be && bt) begin
            off = int'(tg);
            if (off >= 512) off = off - 1024;
            m_pc = (m_pc + off + 1024) % 1024;
            m_ic = m_ic + 1; m_bc = m_bc + 1;
        end else begin
            m_pc = (m_pc + 1) % 1024;
            m_ic = m_ic + 1;
        end
    endfunction

    task automatic drive(input string tag, input logic s, input logic st, input logic h,
                         input logic be, input logic bt, input logic [9:0] tg);
        set_in(s, st, h, be, bt, tg);
        model_edge(s, st, h, be, bt, tg);
        @(posedge Clk);
        #1;
        check_all(tag, m_pc, m_run, m_done, m_ic, m_bc);
    endtask

    initial begin
        // Directed vector table (expected values after the edge).
        tbl.push_back(mk(1,0,0,0,0,10'h000,    0,1,0, 0,0));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0,0,0,0,0,10'h000, k,1,0, k,0));
        tbl.push_back(mk(1,0,0,0,0,10'h000,    6,1,0, 6,0));   // Start ignored in RUN
        for (int k = 7; k <= 10; k++)
            tbl.push_back(mk(0,0,0,0,0,10'h000, k,1,0, k,0));
        tbl.push_back(mk(0,0,0,1,1,10'h3fb,    5,1,0,11,1));   // -5
        tbl.push_back(mk(0,0,0,1,1,10'h002,    7,1,0,12,2));
        tbl.push_back(mk(0,0,0,1,0,10'h3ef,    8,1,0,13,2));   // untaken
        tbl.push_back(mk(0,0,0,0,1,10'h3ef,    9,1,0,14,2));   // BrTaken alone
        tbl.push_back(mk(0,0,1,0,0,10'h000,    9,0,1,15,2));   // halt
        tbl.push_back(mk(0,0,1,1,1,10'h005,    9,0,1,15,2));   // DONE holds
        tbl.push_back(mk(1,0,0,0,0,10'h000,    0,1,0, 0,0));   // restart
        tbl.push_back(mk(0,0,0,1,1,10'h3ef, 1007,1,0, 1,1));   // wrap below 0
        tbl.push_back(mk(0,0,0,1,1,10'h010, 1023,1,0, 2,2));
        tbl.push_back(mk(0,0,0,0,0,10'h000,    0,1,0, 3,2));   // wrap above max
        for (int k = 1; k <= 4; k++)
            tbl.push_back(mk(0,0,0,0,0,10'h000, k,1,0, k+3,2));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,1,1,1,1,10'h020, 4,1,0, 7,2)); // stall beats halt
        tbl.push_back(mk(0,0,1,0,0,10'h000,    4,0,1, 8,2));
        tbl.push_back(mk(0,0,0,0,0,10'h000,    4,0,1, 8,2));
        tbl.push_back(mk(0,0,0,1,1,10'h001,    4,0,1, 8,2));
        tbl.push_back(mk(1,0,0,0,0,10'h000,    0,1,0, 0,0));

        // Reset state while held in reset.
        repeat (2) @(posedge Clk);
        #1;
        check_all("por", 0, 1'b0, 1'b0, 0, 0);
        Reset = 1'b1;
        // Without Start the block stays idle.
        @(posedge Clk);
        #1;
        check_all("idle", 0, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].start, tbl[i].stall, tbl[i].halt, tbl[i].ben, tbl[i].btk, tbl[i].target);
            @(posedge Clk);
            #1;
            check_all($sformatf("v%0d", i), tbl[i].pc, tbl[i].run, tbl[i].done, tbl[i].ic, tbl[i].bc);
        end

        // Mid-cycle asynchronous reset while running at PC=37.
        set_in(0, 0, 0, 1, 1, 10'd37);
        @(posedge Clk);
        #1;
        chk("pre_rst.pc", {22'd0, pc_m}, 32'd37);
        set_in(0, 0, 0, 0, 0, 10'd0);
        #3;
        Reset = 1'b0;
        #1;
        check_all("rst_mid", 0, 1'b0, 1'b0, 0, 0);
        #2;
        Reset = 1'b1;
        model_reset();
        drive("rst_hold", 0, 0, 0, 0, 0, 10'd0);

        // Saturation: 20 instructions, 17 of them taken branches.
        drive("sat_start", 1, 0, 0, 0, 0, 10'd0);
        for (int k = 0; k < 3; k++)
            drive("sat_seq", 0, 0, 0, 0, 0, 10'd0);
        for (int k = 0; k < 17; k++)
            drive("sat_br", 0, 0, 0, 1, 1, 10'd2);
        chk("sat.ic4", {28'd0, ic_s}, 32'd15);
        chk("sat.bc4", {28'd0, bc_s}, 32'd15);
        chk("sat.ic16", {16'd0, ic_m}, 32'd20);
        chk("sat.bc16", {16'd0, bc_m}, 32'd17);
        chk("sat.pc", {22'd0, pc_s}, 32'd37);
        drive("sat_more", 0, 0, 0, 1, 1, 10'd1);
        chk("sat.pc_adv", {22'd0, pc_s}, 32'd38);
        chk("sat.ic4_hold", {28'd0, ic_s}, 32'd15);

        // Randomized stimulus against the reference model.
        for (int k = 0; k < 400; k++) begin
            drive("rnd",
                  ($urandom % 8) == 0,
                  ($urandom % 4) == 0,
                  ($urandom % 20) == 0,
                  ($urandom % 3) == 0,
                  ($urandom % 2) == 0,
                  10'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
